// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider and its subtractor.
package div_pkg;

   // Default operand width of the divider.
   localparam int DIV_N = 32;

   // Divider control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed for an iteration counter that runs from n-1 down to 0,
   // i.e. ceil(log2 n), never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/n_bit_pg_subtractor.sv
// Combinational W-bit subtractor: diff = a + ~b + 1, built on a Kogge-Stone
// parallel-prefix carry network. borrow is the inverted carry out, so it is
// high exactly when a < b (unsigned).
module n_bit_pg_subtractor #(
   parameter int W = 33
) (
   input  logic [W:1] a,
   input  logic [W:1] b,
   output logic [W:1] diff,
   output logic       borrow
);

   // Enough doubling levels to span all W bits plus the carry-in slot.
   localparam int LEVELS = $clog2(W + 1);

   // Slot 0 holds the constant carry-in of 1 as a pure generate; slots 1..W
   // hold the per-bit generate/propagate of a + ~b.
   logic [W:0] g_bit;
   logic [W:0] p_bit;
   logic [W:0] g_grp;

   // Bitwise PG cells.
   always_comb begin
      g_bit = {a & ~b, 1'b1};
      p_bit = {a ^ ~b, 1'b0};
   end

   // Prefix tree: at level l every node combines with the node 2**l below it.
   // Nodes whose span already reaches slot 0 only need the generate term
   // (gray cell); the rest also merge propagate (black cell).
   always_comb begin : prefix_tree
      logic [W:0] g_cur;
      logic [W:0] p_cur;
      logic [W:0] g_new;
      logic [W:0] p_new;
      g_cur = g_bit;
      p_cur = p_bit;
      g_new = '0;
      p_new = '0;
      for (int l = 0; l < LEVELS; l++) begin
         g_new = g_cur;
         p_new = p_cur;
         for (int i = 0; i <= W; i++) begin
            if (i >= (1 << l)) begin
               g_new[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << l)]);
               if (i >= (2 << l)) begin
                  p_new[i] = p_cur[i] & p_cur[i - (1 << l)];
               end
            end
         end
         g_cur = g_new;
         p_cur = p_new;
      end
      g_grp = g_cur;
   end

   // g_grp[k] is the carry out of bit k (carry into bit k+1).
   assign diff   = p_bit[W:1] ^ g_grp[W-1:0];
   assign borrow = ~g_grp[W];

endmodule

// File: rtl/n_bit_restoring_divider.sv
// Iterative unsigned N-bit restoring divider, one trial subtraction per cycle.
//
// Handshake: an operation is accepted on a rising edge where start = 1 and
// ready = 1 (ready is high exactly in IDLE); operands are sampled only then.
// done pulses for one cycle when quotient/remainder (and div_by_zero) are
// updated; those outputs hold until the next completion. start is ignored
// whenever ready = 0.
module n_bit_restoring_divider
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [N:1] dividend,
   input  logic [N:1] divisor,
   output logic       ready,
   output logic       done,
   output logic [N:1] quotient,
   output logic [N:1] remainder,
   output logic       div_by_zero
);

   localparam int CW = cnt_width(N);

   state_t          state;
   state_t          state_nxt;

   // R and D carry one extra bit so the shifted partial remainder never overflows.
   logic [N:0]      r_q;
   logic [N:0]      d_q;
   logic [N-1:0]    q_q;
   logic [CW-1:0]   cnt_q;

   logic [N:0]      trial;
   logic [N:0]      diff;
   logic            borrow;
   logic [N:0]      r_nxt;
   logic [N-1:0]    q_nxt;

   logic            accept;
   logic            zero_div;
   logic            last_iter;

   assign accept    = start && (state == IDLE);
   assign zero_div  = (divisor == '0);
   assign last_iter = (cnt_q == '0);

   assign ready = (state == IDLE);
   assign done  = (state == DONE);

   // Shift the next dividend bit into the partial remainder for this trial.
   assign trial = {r_q[N-1:0], q_q[N-1]};

   n_bit_pg_subtractor #(
      .W (N + 1)
   ) u_sub (
      .a      (trial),
      .b      (d_q),
      .diff   (diff),
      .borrow (borrow)
   );

   // Restore on a failed trial, otherwise keep the difference; quotient bit is ~borrow.
   always_comb begin
      r_nxt = borrow ? trial : diff;
      q_nxt = {q_q[N-2:0], ~borrow};
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic; a zero divisor skips the iterations entirely.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = zero_div ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: load on accept, iterate while busy, publish results on the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q         <= '0;
         d_q         <= '0;
         q_q         <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         d_q         <= {1'b0, divisor};
         q_q         <= dividend;
         r_q         <= '0;
         cnt_q       <= CW'(N - 1);
         div_by_zero <= 1'b0;
         if (zero_div) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == BUSY) begin
         r_q   <= r_nxt;
         q_q   <= q_nxt;
         cnt_q <= cnt_q - CW'(1);
         if (last_iter) begin
            quotient  <= q_nxt;
            remainder <= r_nxt[N-1:0];
         end
      end
   end

endmodule
